reg_dump_reader: RTL and testbench

Sequential read-side companion to the 32×32 register file. On a start request it walks a contiguous (optionally wrapping) range of register addresses through one register-file read port. It streams each `{address, data}` pair out over a valid/ready handshake, one word per cycle when the sink keeps up. Used by the debug/trace path and by test benches to snapshot architectural state without stalling the write port.

---
 rtl/rv_pkg.sv | 15 +
 rtl/reg_dump_reader.sv | 116 +++++++++++
 tb/tb_reg_dump_reader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared register-file constants and the dump FSM state encoding,
// also consumed by the trace controller.
package rv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks a contiguous, optionally wrapping, register range through one read
// port and streams {address, data} pairs over a valid/ready handshake.
module reg_dump_reader
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              slot_free;

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    slot_free   = !out_valid_q || out_ready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = first_addr;
          last_d  = last_addr;
          state_d = RUN;
        end
      end
      RUN: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_addr_d  = cur_q;
          // x0 storage is never written, so its raw read value is meaningless
          out_data_d  = (cur_q == '0) ? '0 : rf_data;
          if (cur_q == last_q) begin
            state_d = DRAIN;
          end else begin
            cur_d = cur_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read address and busy derive only from the upcoming state and cursor
    busy_d    = (state_d != IDLE);
    rf_addr_d = (state_d == RUN) ? cur_d : '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      rf_addr_q   <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      rf_addr_q   <= rf_addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rf_addr   = rf_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: queue-based model of the expected
// word stream, per-cycle compare process, and directed scenarios.
module tb_reg_dump_reader;
  import rv_pkg::*;

  localparam int unsigned AW = REG_ADDR_W;
  localparam int unsigned DW = XLEN;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf_mem [NUM_REGS];
  logic [DW-1:0] seen_data [NUM_REGS];
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] acc_log [$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            acc_cnt  = 0;
  logic          expect_done = 1'b0;

  always #5 clk = ~clk;

  // Register file stand-in: combinational read port
  assign rf_data = rf_mem[rf_addr];

  reg_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Compare process: handshake accepts, stall stability, done timing
  initial begin : compare
    logic          pv;
    logic          pr;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [AW-1:0] a;
    pv = 1'b0; pr = 1'b0; pa = '0; pd = '0; a = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 1'b0;
        expect_done = 1'b0;
      end else begin
        check("done_timing", 64'(done), 64'(expect_done));
        expect_done = 1'b0;
        check("done_with_valid", 64'(done & out_valid), 64'(0));
        if (pv && !pr) begin
          check("stall_valid", 64'(out_valid), 64'(1));
          check("stall_addr", 64'(out_addr), 64'(pa));
          check("stall_data", 64'(out_data), 64'(pd));
        end
        if (out_valid && out_ready) begin
          acc_cnt++;
          acc_log.push_back(out_addr);
          seen_data[out_addr] = out_data;
          check("word_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            a = exp_q.pop_front();
            check("out_addr", 64'(out_addr), 64'(a));
            check("out_data", 64'(out_data), 64'((a == '0) ? '0 : rf_mem[a]));
            if (exp_q.size() == 0) expect_done = 1'b1;
          end
        end
        pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data;
      end
    end
  end

  // Called at posedge+1; returns one ns after the start edge
  task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    logic [AW-1:0] x;
    logic [AW-1:0] span;
    int            n;
    x    = f;
    span = l - f;
    n    = int'(span) + 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(x);
      x = x + AW'(1);
    end
    acc_log.delete();
    start = 1'b1; first_addr = f; last_addr = l;
    @(posedge clk); #1;
    start = 1'b0;
    first_addr = AW'($urandom);
    last_addr  = AW'($urandom);
    check("busy_after_start", 64'(busy), 64'(1));
    check("valid_after_start", 64'(out_valid), 64'(0));
  endtask

  task automatic wait_done(input bit bp, output int cyc, output int bcyc);
    bit got;
    got  = 1'b0;
    bcyc = busy ? 1 : 0;
    cyc  = 0;
    while (!got && cyc < 300) begin
      if (bp) out_ready = ($urandom_range(0, 99) < 30);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check("first_valid", 64'(out_valid), 64'(1));
      if (busy) bcyc++;
      if (done) got = 1'b1;
    end
    out_ready = 1'b1;
    check("done_seen", 64'(got), 64'(1));
    check("words_left", 64'(exp_q.size()), 64'(0));
    check("rf_addr_idle", 64'(rf_addr), 64'(0));
  endtask

  initial begin : directed
    int cyc;
    int bcyc;
    int acc0;
    rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b1;
    for (int i = 0; i < int'(NUM_REGS); i++)
      rf_mem[AW'(i)] = (i == 0) ? 32'hDEAD_BEEF : 32'h1000_0000 + DW'(i);
    #1 rst = 1'b0;
    #2;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rf_addr", 64'(rf_addr), 64'(0));
    check("rst_out_addr", 64'(out_addr), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Full dump 0..31
    acc0 = acc_cnt;
    do_start(5'd0, 5'd31);
    wait_done(1'b0, cyc, bcyc);
    check("full_done_cycle", 64'(cyc), 64'(33));
    check("full_busy_cycles", 64'(bcyc), 64'(33));
    check("full_count", 64'(acc_cnt - acc0), 64'(32));
    check("full_x0_data", 64'(seen_data[0]), 64'(32'h0));
    check("full_x5_data", 64'(seen_data[5]), 64'(32'h1000_0005));
    check("full_x31_data", 64'(seen_data[31]), 64'(32'h1000_001F));
    check("full_first_addr", 64'(acc_log[0]), 64'(0));
    check("full_last_addr", 64'(acc_log[31]), 64'(31));

    // Wrap 30..1
    acc0 = acc_cnt;
    do_start(5'd30, 5'd1);
    wait_done(1'b0, cyc, bcyc);
    check("wrap_done_cycle", 64'(cyc), 64'(5));
    check("wrap_busy_cycles", 64'(bcyc), 64'(5));
    check("wrap_count", 64'(acc_cnt - acc0), 64'(4));
    check("wrap_addr0", 64'(acc_log[0]), 64'(30));
    check("wrap_addr1", 64'(acc_log[1]), 64'(31));
    check("wrap_addr2", 64'(acc_log[2]), 64'(0));
    check("wrap_addr3", 64'(acc_log[3]), 64'(1));

    // Backpressure 5..9
    acc0 = acc_cnt;
    do_start(5'd5, 5'd9);
    wait_done(1'b1, cyc, bcyc);
    check("bp_count", 64'(acc_cnt - acc0), 64'(5));
    check("bp_first_addr", 64'(acc_log[0]), 64'(5));
    check("bp_last_addr", 64'(acc_log[4]), 64'(9));

    // Single word 7
    acc0 = acc_cnt;
    do_start(5'd7, 5'd7);
    wait_done(1'b0, cyc, bcyc);
    check("single_done_cycle", 64'(cyc), 64'(2));
    check("single_count", 64'(acc_cnt - acc0), 64'(1));
    check("single_addr", 64'(acc_log[0]), 64'(7));
    check("single_data", 64'(seen_data[7]), 64'(32'h1000_0007));

    // Start pulse while a dump of 10..20 is running
    acc0 = acc_cnt;
    do_start(5'd10, 5'd20);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, cyc, bcyc);
    check("busy_start_done_cycle", 64'(cyc), 64'(8));
    check("busy_start_count", 64'(acc_cnt - acc0), 64'(11));

    // Asynchronous reset mid-dump, then a fresh dump 3..4
    do_start(5'd0, 5'd31);
    repeat (5) begin @(posedge clk); #1; end
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_rf_addr", 64'(rf_addr), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    acc0 = acc_cnt;
    do_start(5'd3, 5'd4);
    wait_done(1'b0, cyc, bcyc);
    check("post_reset_done_cycle", 64'(cyc), 64'(3));
    check("post_reset_count", 64'(acc_cnt - acc0), 64'(2));
    check("post_reset_addr0", 64'(acc_log[0]), 64'(3));
    check("post_reset_addr1", 64'(acc_log[1]), 64'(4));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
